// File: rtl/rvc_asap_cr_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : rvc_asap_cr_mem_if
//  Purpose  : Core data-port bus toward the CR region responder. The core
//             side drives address/data/strobes; the responder returns q.
//  Revision : 1.0 - initial release
// ============================================================================
interface rvc_asap_cr_mem_if;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  byte_en;
  logic [31:0] q;

  modport master (
    output address,
    output data_in,
    output wr_en,
    output rd_en,
    output byte_en,
    input  q
  );

  modport slave (
    input  address,
    input  data_in,
    input  wr_en,
    input  rd_en,
    input  byte_en,
    output q
  );
endinterface
`default_nettype wire

// File: rtl/rvc_asap_cr_mem.sv
`default_nettype none
// ============================================================================
//  Module   : rvc_asap_cr_mem
//  Purpose  : Control-register responder for the CR window. Holds the
//             seven-segment, LED and VGA cursor registers, and presents
//             synchronized switches and synchronized + debounced buttons
//             to core loads.
//  Revision : 1.0 - initial release
// ============================================================================
module rvc_asap_cr_mem #(
  parameter logic [31:0] CR_BASE         = 32'h0000_7000,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  rvc_asap_cr_mem_if.slave cr_bus,
  input  wire logic        button_0_i,
  input  wire logic        button_1_i,
  input  wire logic [9:0]  switch_i,
  output logic [7:0]       seg7_0_o,
  output logic [7:0]       seg7_1_o,
  output logic [7:0]       seg7_2_o,
  output logic [7:0]       seg7_3_o,
  output logic [7:0]       seg7_4_o,
  output logic [7:0]       seg7_5_o,
  output logic [9:0]       led_o,
  output logic [31:0]      cursor_h_o,
  output logic [31:0]      cursor_v_o
);

  // Word indices within the CR window
  localparam logic [9:0] W_SEG7_5 = 10'd5;
  localparam logic [9:0] W_LED    = 10'd6;
  localparam logic [9:0] W_BTN0   = 10'd7;
  localparam logic [9:0] W_BTN1   = 10'd8;
  localparam logic [9:0] W_SWITCH = 10'd9;
  localparam logic [9:0] W_CUR_H  = 10'd10;
  localparam logic [9:0] W_CUR_V  = 10'd11;

  // Raw board input vector layout: {switch[9:0], button_1, button_0}
  localparam int IN_W = 12;

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_e;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [31:0] offset;
  logic        hit;
  logic [9:0]  word_idx;
  logic        wr_hit;
  logic        unused_ok;

  assign offset    = cr_bus.address - CR_BASE;
  assign hit       = (cr_bus.address >= CR_BASE) &&
                     (cr_bus.address <= (CR_BASE + 32'h0000_0FFF));
  assign word_idx  = offset[11:2];
  assign wr_hit    = cr_bus.wr_en & hit;
  // Byte offset within a word and bits above the window play no part in decode
  assign unused_ok = ^{offset[31:12], offset[1:0]};

  // --------------------------------------------------------------------------
  // RW registers
  // --------------------------------------------------------------------------
  logic [7:0]  seg7_q [6];
  logic [9:0]  led_q;
  logic [31:0] cur_h_q;
  logic [31:0] cur_v_q;

  // Byte-lane writes into RW registers; only implemented bits are stored
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 6; i++) seg7_q[i] <= '0;
      led_q   <= '0;
      cur_h_q <= '0;
      cur_v_q <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < 6; i++) begin
        if ((word_idx == 10'(i)) && cr_bus.byte_en[0]) seg7_q[i] <= cr_bus.data_in[7:0];
      end
      if (word_idx == W_LED) begin
        if (cr_bus.byte_en[0]) led_q[7:0] <= cr_bus.data_in[7:0];
        if (cr_bus.byte_en[1]) led_q[9:8] <= cr_bus.data_in[9:8];
      end
      for (int b = 0; b < 4; b++) begin
        if ((word_idx == W_CUR_H) && cr_bus.byte_en[b]) cur_h_q[8*b +: 8] <= cr_bus.data_in[8*b +: 8];
        if ((word_idx == W_CUR_V) && cr_bus.byte_en[b]) cur_v_q[8*b +: 8] <= cr_bus.data_in[8*b +: 8];
      end
    end
  end

  assign seg7_0_o   = seg7_q[0];
  assign seg7_1_o   = seg7_q[1];
  assign seg7_2_o   = seg7_q[2];
  assign seg7_3_o   = seg7_q[3];
  assign seg7_4_o   = seg7_q[4];
  assign seg7_5_o   = seg7_q[5];
  assign led_o      = led_q;
  assign cursor_h_o = cur_h_q;
  assign cursor_v_o = cur_v_q;

  // --------------------------------------------------------------------------
  // Board input synchronizers
  // --------------------------------------------------------------------------
  logic [IN_W-1:0] sync_q [SYNC_STAGES];
  logic [IN_W-1:0] sync_last;

  // Shift raw asynchronous levels through the synchronizer chain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= {switch_i, button_1_i, button_0_i};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Button debouncers: a change is accepted only after it has been held for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level
  // before that discards the partial count.
  // --------------------------------------------------------------------------
  logic [1:0] deb;

  for (genvar b = 0; b < 2; b++) begin : g_deb
    deb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             deb_q;

    // Per-button debounce FSM with its stability counter
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        deb_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_STABLE: begin
            cnt_q <= '0;
            if (sync_last[b] != deb_q) state_q <= ST_COUNTING;
          end
          ST_COUNTING: begin
            if (sync_last[b] == deb_q) begin
              cnt_q   <= '0;
              state_q <= ST_STABLE;
            end else if (cnt_q == CNT_MAX) begin
              deb_q   <= sync_last[b];
              cnt_q   <= '0;
              state_q <= ST_STABLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_STABLE;
          end
        endcase
      end
    end

    assign deb[b] = deb_q;
  end

  // --------------------------------------------------------------------------
  // Load path
  // --------------------------------------------------------------------------
  logic [31:0] rd_data_d;
  logic [31:0] q_q;

  // Select the addressed register, zero-extended; unmapped or no-hit reads zero
  always_comb begin
    rd_data_d = '0;
    if (hit) begin
      if (word_idx <= W_SEG7_5) begin
        rd_data_d = {24'h0, seg7_q[word_idx[2:0]]};
      end else begin
        case (word_idx)
          W_LED:    rd_data_d = {22'h0, led_q};
          W_BTN0:   rd_data_d = {31'h0, deb[0]};
          W_BTN1:   rd_data_d = {31'h0, deb[1]};
          W_SWITCH: rd_data_d = {22'h0, sync_last[IN_W-1:2]};
          W_CUR_H:  rd_data_d = cur_h_q;
          W_CUR_V:  rd_data_d = cur_v_q;
          default:  rd_data_d = '0;
        endcase
      end
    end
  end

  // Capture load data on rd_en; hold between loads
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (cr_bus.rd_en) begin
      q_q <= rd_data_d;
    end
  end

  assign cr_bus.q = q_q;

endmodule
`default_nettype wire
